// File: rtl/regfile_wb_pkg.sv
// Shared widths and the buffered writeback entry used by the register-file
// write arbiter and its long-latency FIFO.
package regfile_wb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;

endpackage : regfile_wb_pkg

// File: rtl/wb_fifo.sv
// Small FIFO of long-latency writebacks; entries can be killed in place by a
// newer write to the same register, and dead entries stay until popped.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          Clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [REG_AW-1:0]             push_rd,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  input  logic                          kill_en,
  input  logic [REG_AW-1:0]             kill_rd,
  output logic                          full,
  output logic                          empty,
  output wb_entry_t                     head,
  output logic [DEPTH-1:0]              live,
  output logic [DEPTH-1:0][REG_AW-1:0]  rd
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic             push_live_c;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign head        = mem[head_ptr];
  // An entry arriving alongside a primary write to the same register is already stale.
  assign push_live_c = !(kill_en && (kill_rd == push_rd));

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_export
    assign live[g] = mem[g].live;
    assign rd[g]   = mem[g].rd;
  end

  always_ff @(posedge Clk) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (kill_en && (mem[i].rd == kill_rd)) mem[i].live <= 1'b0;
      end
      if (pop) begin
        mem[head_ptr].live <= 1'b0;
        head_ptr           <= head_ptr + PTR_W'(1);
      end
      if (push) begin
        mem[tail_ptr].rd   <= push_rd;
        mem[tail_ptr].data <= push_data;
        mem[tail_ptr].live <= push_live_c;
        tail_ptr           <= tail_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : wb_fifo

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writebacks and buffered long-latency results onto the single
// register-file write port; the pipeline always wins, with an advisory stall.
module regfile_write_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                Clk,
  input  logic                rst,
  input  logic                pipe_wen,
  input  logic [REG_AW-1:0]   pipe_rd,
  input  logic [DATA_W-1:0]   pipe_data,
  input  logic                lu_valid,
  input  logic [REG_AW-1:0]   lu_rd,
  input  logic [DATA_W-1:0]   lu_data,
  output logic                lu_ready,
  output logic                WEN,
  output logic [REG_AW-1:0]   RW,
  output logic [DATA_W-1:0]   busW,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                pipe_stall
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                         full;
  logic                         empty;
  wb_entry_t                    head;
  logic [DEPTH-1:0]             live;
  logic [DEPTH-1:0][REG_AW-1:0] rd;
  logic                         pri_c;
  logic                         pop_c;
  logic                         push_c;
  logic [STARVE_W-1:0]          starve_q;
  logic [STARVE_W-1:0]          starve_next_c;

  assign lu_ready = rst && !full;
  assign pri_c    = pipe_wen && (pipe_rd != '0);
  // Dead heads drain every cycle; live heads only when the pipeline is idle.
  assign pop_c    = !empty && (!head.live || !pri_c);
  assign push_c   = lu_valid && lu_ready && (lu_rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk       (Clk),
    .rst       (rst),
    .push      (push_c),
    .push_rd   (lu_rd),
    .push_data (lu_data),
    .pop       (pop_c),
    .kill_en   (pri_c),
    .kill_rd   (pipe_rd),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .live      (live),
    .rd        (rd)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (live[i]) pending_mask[rd[i]] = 1'b1;
    end
  end

  always_comb begin
    starve_next_c = starve_q;
    if (empty || pop_c)
      starve_next_c = '0;
    else if (head.live && (starve_q != STARVE_W'(STARVE_LIMIT)))
      starve_next_c = starve_q + STARVE_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!rst) begin
      WEN        <= 1'b0;
      RW         <= '0;
      busW       <= '0;
      starve_q   <= '0;
      pipe_stall <= 1'b0;
    end else begin
      starve_q   <= starve_next_c;
      pipe_stall <= (starve_next_c == STARVE_W'(STARVE_LIMIT));
      WEN        <= 1'b0;
      if (pri_c) begin
        WEN  <= 1'b1;
        RW   <= pipe_rd;
        busW <= pipe_data;
      end else if (pop_c && head.live) begin
        WEN  <= 1'b1;
        RW   <= head.rd;
        busW <= head.data;
      end
    end
  end

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: primary writes, FIFO drain,
// backpressure, WAW kill, starvation stall and reset mid-operation.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        WEN;
  logic [4:0]  RW;
  logic [31:0] busW;
  logic [31:0] pending_mask;
  logic        pipe_stall;

  int n_cmp = 0;
  int n_err = 0;

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .Clk          (Clk),
    .rst          (rst),
    .pipe_wen     (pipe_wen),
    .pipe_rd      (pipe_rd),
    .pipe_data    (pipe_data),
    .lu_valid     (lu_valid),
    .lu_rd        (lu_rd),
    .lu_data      (lu_data),
    .lu_ready     (lu_ready),
    .WEN          (WEN),
    .RW           (RW),
    .busW         (busW),
    .pending_mask (pending_mask),
    .pipe_stall   (pipe_stall)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    pipe_wen  = 1'b0;
    pipe_rd   = '0;
    pipe_data = '0;
    lu_valid  = 1'b0;
    lu_rd     = '0;
    lu_data   = '0;
  endtask

  task automatic pri(input logic [4:0] r, input logic [31:0] d);
    pipe_wen  = 1'b1;
    pipe_rd   = r;
    pipe_data = d;
  endtask

  task automatic lu(input logic [4:0] r, input logic [31:0] d);
    lu_valid = 1'b1;
    lu_rd    = r;
    lu_data  = d;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] r, input logic [31:0] d);
    chk({tag, "_wen"}, 32'(WEN), 32'd1);
    chk({tag, "_rw"}, 32'(RW), 32'(r));
    chk({tag, "_busw"}, busW, d);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_wen", 32'(WEN), 32'd0);
    chk("rst_rw", 32'(RW), 32'd0);
    chk("rst_busw", busW, 32'd0);
    chk("rst_pending", pending_mask, 32'd0);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_ready", 32'(lu_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 32'(lu_ready), 32'd1);

    // primary write, then rd==0 request which must not write
    pri(5'd5, 32'hDEADBEEF);
    tick();
    chk_wr("pri5", 5'd5, 32'hDEADBEEF);
    pri(5'd0, 32'h1);
    tick();
    chk("pri0_wen", 32'(WEN), 32'd0);
    idle();
    tick();

    // long-latency drain into idle slot
    lu(5'd7, 32'h12);
    tick();
    idle();
    chk("drain_pend_set", pending_mask, 32'h0000_0080);
    chk("drain_nowen", 32'(WEN), 32'd0);
    tick();
    chk_wr("drain7", 5'd7, 32'h12);
    chk("drain_pend_clr", pending_mask, 32'd0);
    tick();
    chk("drain_idle", 32'(WEN), 32'd0);

    // backpressure with the primary busy every cycle
    pri(5'd1, 32'h100);
    lu(5'd10, 32'hA0);
    tick();
    chk_wr("bp_pri1", 5'd1, 32'h100);
    chk("bp_ready1", 32'(lu_ready), 32'd1);
    pri(5'd2, 32'h200);
    lu(5'd11, 32'hB0);
    tick();
    chk("bp_full_ready", 32'(lu_ready), 32'd0);
    chk("bp_pend2", pending_mask, 32'h0000_0C00);
    lu(5'd12, 32'hC0);
    tick();
    chk_wr("bp_pri2", 5'd2, 32'h200);
    chk("bp_still_full", 32'(lu_ready), 32'd0);
    chk("bp_pend_no12", pending_mask, 32'h0000_0C00);
    idle();
    tick();
    chk_wr("bp_d10", 5'd10, 32'hA0);
    chk("bp_ready_back", 32'(lu_ready), 32'd1);
    chk("bp_pend11", pending_mask, 32'h0000_0800);
    tick();
    chk_wr("bp_d11", 5'd11, 32'hB0);
    chk("bp_pend_empty", pending_mask, 32'd0);
    tick();
    chk("bp_idle", 32'(WEN), 32'd0);

    // WAW kill of a buffered entry by a later primary write
    lu(5'd9, 32'hA);
    tick();
    idle();
    chk("waw_pend_set", pending_mask, 32'h0000_0200);
    pri(5'd9, 32'hB);
    tick();
    idle();
    chk_wr("waw_pri9", 5'd9, 32'hB);
    chk("waw_pend_clr", pending_mask, 32'd0);
    tick();
    chk("waw_nowrite1", 32'(WEN), 32'd0);
    tick();
    chk("waw_nowrite2", 32'(WEN), 32'd0);

    // entry pushed in the same cycle as a primary write to its rd is dead
    pri(5'd6, 32'h77);
    lu(5'd6, 32'h66);
    tick();
    idle();
    chk_wr("samecyc_pri6", 5'd6, 32'h77);
    chk("samecyc_pend", pending_mask, 32'd0);
    tick();
    chk("samecyc_nowrite1", 32'(WEN), 32'd0);
    tick();
    chk("samecyc_nowrite2", 32'(WEN), 32'd0);

    // lu_rd==0 accepted and discarded
    lu(5'd0, 32'h55);
    tick();
    idle();
    chk("rd0_pend", pending_mask, 32'd0);
    tick();
    chk("rd0_nowrite", 32'(WEN), 32'd0);

    // starvation: head waits behind continuous primary traffic
    lu(5'd3, 32'h33);
    tick();
    idle();
    chk("st_pend", pending_mask, 32'h0000_0008);
    pri(5'd4, 32'h44);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_wr("st_pri4", 5'd4, 32'h44);
      chk($sformatf("st_stall_%0d", i), 32'(pipe_stall), (i == 4) ? 32'd1 : 32'd0);
    end
    tick();
    chk("st_stall_sat", 32'(pipe_stall), 32'd1);
    chk("st_pend_hold", pending_mask, 32'h0000_0008);
    idle();
    tick();
    chk_wr("st_d3", 5'd3, 32'h33);
    chk("st_stall_fall", 32'(pipe_stall), 32'd0);
    chk("st_pend_clr", pending_mask, 32'd0);

    // reset mid-operation discards two live entries
    pri(5'd1, 32'h1);
    lu(5'd20, 32'h14);
    tick();
    lu(5'd21, 32'h15);
    tick();
    idle();
    chk("mr_pend", pending_mask, 32'h0030_0000);
    rst = 1'b0;
    tick();
    chk("mr_wen", 32'(WEN), 32'd0);
    chk("mr_pend_clr", pending_mask, 32'd0);
    chk("mr_ready_low", 32'(lu_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("mr_ready_high", 32'(lu_ready), 32'd1);
    chk("mr_nowrite1", 32'(WEN), 32'd0);
    tick();
    chk("mr_nowrite2", 32'(WEN), 32'd0);
    chk("mr_pend_end", pending_mask, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_write_arbiter

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Serializes register-file writebacks from two producers onto the register file's single write port (WEN/RW/busW). The main pipeline writeback always wins. A long-latency unit (divider, load miss) has its results buffered in a small FIFO and drained into idle write slots. The block sits between the writeback stage / long-latency unit and the register file, and exports a pending-register mask for decode hazard checks.

## Interface
- DEPTH, 2: FIFO entries for long-latency results (power of two, ≥2)
- STARVE_LIMIT, 4: cycles a live FIFO head may wait before pipe_stall asserts
- Clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- pipe_wen  in  1  primary writeback request; never back-pressured
- pipe_rd  in  5  primary destination register
- pipe_data  in  32  primary write data
- lu_valid  in  1  long-latency result valid
- lu_rd  in  5  long-latency destination register
- lu_data  in  32  long-latency result data
- lu_ready  out  1  FIFO can accept; transfer when lu_valid && lu_ready
- WEN  out  1  register file write enable (registered)
- RW  out  5  register file write address (registered)
- busW  out  32  register file write data (registered)
- pending_mask  out  32  bit r set while a live FIFO entry targets register r
- pipe_stall  out  1  registered request for upstream to insert a writeback bubble

## Operation
- Enqueue: on an lu_valid && lu_ready transfer with lu_rd != 0, push {rd, data, live=1}. With lu_rd == 0, the transfer is accepted and discarded.
- lu_ready = !full, computed from registered count only. It stays 0 when full, even if a pop occurs in the same cycle.
- Select each cycle, in priority order:
  - pipe_wen && pipe_rd != 0: issue the primary write.
  - Else, if the head is live: pop it and issue its write.
  - Else: no write.
- pipe_wen with pipe_rd == 0 counts as no request.
- A dead head is popped in any cycle, including cycles where the primary write wins, and produces no write.
- WAW kill: a primary write to rd X clears live on every FIFO entry with rd == X in the same cycle. An entry pushed in that same cycle with rd X is pushed dead.
- pending_mask: OR of the one-hot rd of all live entries, from registered state.
- Starvation counter:
  - Increments in each cycle the head is live and not popped.
  - Clears on pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- pipe_stall = (counter == STARVE_LIMIT), registered. The stall is advisory: if pipe_wen still asserts, the primary write wins.
- Simultaneous push and pop: both occur and count is unchanged. A push into an empty FIFO cannot be popped in the same cycle.

## Timing
- Reset (rst == 0 at posedge):
  - WEN=0, RW=0, busW=0.
  - FIFO empty, counter=0, pending_mask=0, pipe_stall=0.
  - lu_ready=0 while rst is low; lu_ready=1 from the first cycle after release.
- Reset mid-operation discards all buffered entries without writing them.
- Primary write: request in cycle N → WEN/RW/busW valid in cycle N+1, for one cycle.
- Long-latency write: pushed in cycle N → earliest WEN in cycle N+2 (pop in N+1, output in N+2).
- pending_mask bit sets in the cycle after the push. It clears in the cycle after the pop or kill.
- FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.

## Structure
- Package regfile_wb_pkg:
  - DATA_W=32, REG_AW=5, NUM_REGS=32.
  - Struct wb_entry_t {rd, data, live}.
- Sub-module wb_fifo, parameterized by DEPTH:
  - Storage array, head/tail pointers, count.
  - Per-entry kill by rd match.
  - Exports live vector and rd array for pending_mask.
- The top level holds select logic, output registers and the starvation counter.

## Test plan
- Reset then primary only: pipe_wen=1, rd=5, data=0xDEADBEEF in cycle 3 → WEN=1, RW=5, busW=0xDEADBEEF in cycle 4. rd=0 → WEN stays 0.
- LU drain: empty FIFO, push rd=7, data=0x12 at cycle N, no primary traffic → pending_mask[7]=1 at N+1, WEN/RW=7/0x12 at N+2, pending_mask=0 at N+2.
- Backpressure: primary busy every cycle, push 2 entries → lu_ready=0 with count=2. Release the primary → entries drain in push order, lu_ready returns to 1.
- WAW kill: push rd=9 data=0xA, then primary rd=9 data=0xB in the next cycle → only 0xB is ever written to r9. pending_mask[9] clears, no later write to r9.
- Starvation: push rd=3, hold pipe_wen=1 to rd=4 → pipe_stall=1 after STARVE_LIMIT=4 waiting cycles. Drop pipe_wen → r3 written next cycle, pipe_stall falls.
- Reset mid-operation: FIFO holding 2 live entries, assert rst for 1 cycle → no WEN for those entries, pending_mask=0, lu_ready=0 during reset then 1.
